// File: rtl/sum_bcd_display_pkg.sv
// Shared types, segment codes and the double-dabble nibble correction for sum_bcd_display.
package sum_display_pkg;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  // Active-low segment codes, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  function automatic logic [3:0] add3_nibble(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/sum_bcd_display_if.sv
// Conversion request/result bundle between the adder datapath, this block and the HEX pins.
interface sum_bcd_display_if #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned NDIG  = 6
);
  logic                  Start;
  logic [WIDTH-1:0]      S;
  logic                  Busy;
  logic                  Done;
  logic [4*NDIG-1:0]     Digits;
  logic [6:0]            HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  modport master (
    output Start, S,
    input  Busy, Done, Digits, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
  );

  modport slave (
    input  Start, S,
    output Busy, Done, Digits, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
  );
endinterface

// File: rtl/sum_bcd_display_bcd_to_sevenseg.sv
// Combinational BCD digit to active-low 7-segment decoder; non-decimal codes go dark.
module bcd_to_sevenseg
  import sum_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sum_bcd_display.sv
// Binary-to-BCD (shift-add-3) converter driving six active-low 7-segment displays.
module sum_bcd_display
  import sum_display_pkg::*;
#(
  parameter int unsigned WIDTH    = 17,
  parameter int unsigned NDIG     = 6,
  parameter bit          BLANK_LZ = 1'b1
) (
  input logic             Clk,
  input logic             Reset_Clear,
  sum_bcd_display_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam int unsigned BcdW = 4 * NDIG;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [WIDTH-1:0]  bin_q;
  logic [BcdW-1:0]   bcd_q;
  logic [BcdW-1:0]   bcd_adj;
  logic              busy_q;
  logic              done_q;
  logic [BcdW-1:0]   digits_q;
  logic [6:0]        hex_q   [NDIG];
  logic [6:0]        hex_d   [NDIG];
  logic [6:0]        seg_raw [NDIG];
  logic [NDIG-1:0]   upper_nz;

  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < int'(NDIG); i++) begin
      bcd_adj[4*i +: 4] = add3_nibble(bcd_q[4*i +: 4]);
    end
  end

  for (genvar g = 0; g < int'(NDIG); g++) begin : g_seg
    bcd_to_sevenseg u_seg (
      .bcd (bcd_q[4*g +: 4]),
      .seg (seg_raw[g])
    );
  end

  // upper_nz[n] is set when any digit n..NDIG-1 is non-zero
  always_comb begin
    logic nz;
    nz       = 1'b0;
    upper_nz = '0;
    for (int i = int'(NDIG) - 1; i >= 0; i--) begin
      nz          = nz | (|bcd_q[4*i +: 4]);
      upper_nz[i] = nz;
    end
    for (int i = 0; i < int'(NDIG); i++) begin
      hex_d[i] = (BLANK_LZ && (i != 0) && !upper_nz[i]) ? SEG_BLANK : seg_raw[i];
    end
  end

  always_ff @(posedge Clk or negedge Reset_Clear) begin
    if (!Reset_Clear) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      bin_q    <= '0;
      bcd_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      digits_q <= '0;
      for (int i = 0; i < int'(NDIG); i++) begin
        hex_q[i] <= (BLANK_LZ && (i != 0)) ? SEG_BLANK : SEG_0;
      end
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.Start) begin
            state_q <= StShift;
            bin_q   <= bus.S;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        StShift: begin
          {bcd_q, bin_q} <= {bcd_adj[BcdW-2:0], bin_q, 1'b0};
          cnt_q          <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(WIDTH - 1)) state_q <= StDone;
        end
        StDone: begin
          digits_q <= bcd_q;
          hex_q    <= hex_d;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.Busy   = busy_q;
  assign bus.Done   = done_q;
  assign bus.Digits = digits_q;
  assign bus.HEX0   = hex_q[0];
  assign bus.HEX1   = hex_q[1];
  assign bus.HEX2   = hex_q[2];
  assign bus.HEX3   = hex_q[3];
  assign bus.HEX4   = hex_q[4];
  assign bus.HEX5   = hex_q[5];

endmodule
